// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back front end.
package regfile_wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic                  is_fp;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // Integer x0 is hardwired to zero, so writes to it are accepted and discarded.
  function automatic logic is_x0_drop(input logic is_fp, input logic [REG_ADDR_W-1:0] addr);
    return !is_fp && (addr == '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small write-back FIFO; exposes its storage and per-slot valid mask so the
// owner can decode which registers still have writes queued.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  output wb_entry_t             head_o,
  output logic [CNT_W-1:0]      count_o,
  output wb_entry_t [DEPTH-1:0] entries_o,
  output logic [DEPTH-1:0]      valid_o,
  output logic                  empty_o,
  output logic                  full_o
);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // NOTE: storage is deliberately left unreset; count/valid_o decide what is live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
    else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [PTR_W-1:0] age;
    assign age        = PTR_W'(i) - rd_ptr_q;
    assign valid_o[i] = CNT_W'(age) < count_q;
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back front end: round-robin result arbitration, FIFO
// buffering, one write per cycle to the RF port, and pending-write bitmaps.
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*XLEN-1:0]       src_data,
  input  logic [NUM_SRC-1:0]            src_is_fp,
  input  logic                          rf_busy,
  output logic                          rf_write_enable,
  output logic [REG_ADDR_W-1:0]         rf_write_addr,
  output logic [XLEN-1:0]               rf_write_data,
  output logic                          rf_is_fp,
  output logic [NUM_REGS-1:0]           pending_int,
  output logic [NUM_REGS-1:0]           pending_fp,
  output logic                          wb_idle
);

  localparam int RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [RR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  grant_found;
  logic [RR_W-1:0]       grant_idx;
  wb_entry_t             sel_entry;
  logic                  pop, push, accept, can_push;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      entry_valid;
  logic [CNT_W-1:0]      count;
  logic                  empty, full;

  function automatic logic [RR_W-1:0] rr_index(input logic [RR_W-1:0] base, input int offset);
    int s;
    s = int'(base) + offset;
    if (s >= NUM_SRC) s -= NUM_SRC;
    return RR_W'(s);
  endfunction

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!grant_found && src_valid[rr_index(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = rr_index(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    sel_entry.is_fp = src_is_fp[grant_idx];
    sel_entry.addr  = src_addr[grant_idx*REG_ADDR_W +: REG_ADDR_W];
    sel_entry.data  = src_data[grant_idx*XLEN +: XLEN];
  end

  assign pop      = !empty && !rf_busy;
  assign can_push = !full || pop;
  assign accept   = grant_found && can_push;
  assign push     = accept && !is_x0_drop(sel_entry.is_fp, sel_entry.addr);

  always_comb begin
    src_ready = '0;
    if (accept) src_ready[grant_idx] = 1'b1;
  end

  assign rr_ptr_d = accept ? rr_index(grant_idx, 1) : rr_ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_entry_i(sel_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .entries_o   (entries),
    .valid_o     (entry_valid),
    .empty_o     (empty),
    .full_o      (full)
  );

  assign rf_write_enable = pop;
  assign rf_write_addr   = head.addr;
  assign rf_write_data   = head.data;
  assign rf_is_fp        = head.is_fp;
  assign wb_idle         = (count == '0);

  always_comb begin
    pending_int = '0;
    pending_fp  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        if (entries[i].is_fp) pending_fp[entries[i].addr]  = 1'b1;
        else                  pending_int[entries[i].addr] = 1'b1;
      end
    end
    pending_int[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed and randomized checks of regfile_writeback against a queue-based model.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  src_valid, src_ready, src_is_fp;
  logic [14:0] src_addr;
  logic [95:0] src_data;
  logic        rf_busy;
  logic        rf_write_enable, rf_is_fp, wb_idle;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data, pending_int, pending_fp;

  regfile_writeback #(.NUM_SRC(3), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .src_addr       (src_addr),
    .src_data       (src_data),
    .src_is_fp      (src_is_fp),
    .rf_busy        (rf_busy),
    .rf_write_enable(rf_write_enable),
    .rf_write_addr  (rf_write_addr),
    .rf_write_data  (rf_write_data),
    .rf_is_fp       (rf_is_fp),
    .pending_int    (pending_int),
    .pending_fp     (pending_fp),
    .wb_idle        (wb_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        is_fp;
    bit [4:0]  addr;
    bit [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_rr;
  int   tests;
  int   fails;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input bit v, input bit fp, input bit [4:0] a, input bit [31:0] d);
    src_valid[i]        = v;
    src_is_fp[i]        = fp;
    src_addr[i*5 +: 5]  = a;
    src_data[i*32 +: 32] = d;
  endtask

  // Called at a negedge with inputs settled; checks one cycle, then advances the model.
  task automatic step(output int g);
    bit       pop, canp;
    int       gi, idx;
    bit [2:0] er;
    bit [31:0] pi, pf;
    ent_t     e;
    #1;
    pop  = (mq.size() > 0) && !rf_busy;
    canp = (mq.size() < 4) || pop;
    gi   = -1;
    for (int k = 0; k < 3; k++) begin
      idx = (m_rr + k) % 3;
      if (gi < 0 && src_valid[idx]) gi = idx;
    end
    er = (gi >= 0 && canp) ? 3'(1 << gi) : 3'b000;
    check("src_ready", src_ready, er);
    check("rf_write_enable", rf_write_enable, pop);
    if (mq.size() > 0) begin
      check("rf_write_addr", rf_write_addr, mq[0].addr);
      check("rf_write_data", rf_write_data, mq[0].data);
      check("rf_is_fp", rf_is_fp, mq[0].is_fp);
    end
    pi = '0;
    pf = '0;
    foreach (mq[j]) begin
      if (mq[j].is_fp) pf[mq[j].addr] = 1'b1;
      else             pi[mq[j].addr] = 1'b1;
    end
    pi[0] = 1'b0;
    check("pending_int", pending_int, pi);
    check("pending_fp", pending_fp, pf);
    check("wb_idle", wb_idle, mq.size() == 0);
    if (er != 0) begin
      e.is_fp = src_is_fp[gi];
      e.addr  = src_addr[gi*5 +: 5];
      e.data  = src_data[gi*32 +: 32];
    end
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (er != 0) begin
      if (e.is_fp || e.addr != 0) mq.push_back(e);
      m_rr = (gi + 1) % 3;
    end
    g = (er != 0) ? gi : -1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    src_valid = '0;
    reset     = 1'b1;
    #1;
    check("rst_we", rf_write_enable, 1'b0);
    check("rst_ready", src_ready, 3'b000);
    check("rst_pend_int", pending_int, 32'h0);
    check("rst_pend_fp", pending_fp, 32'h0);
    check("rst_idle", wb_idle, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    m_rr = 0;
  endtask

  task automatic single_x5();
    int g;
    set_src(0, 1, 0, 5'd5, 32'hDEADBEEF);
    step(g);
    check("x5_grant", g, 0);
    src_valid = '0;
    #1;
    check("x5_we", rf_write_enable, 1'b1);
    check("x5_addr", rf_write_addr, 5'd5);
    check("x5_data", rf_write_data, 32'hDEADBEEF);
    check("x5_pend", pending_int, 32'h20);
    step(g);
    check("x5_pend_clr", pending_int, 32'h0);
    step(g);
  endtask

  initial begin
    int g, acc;
    int exp_g;
    tests     = 0;
    fails     = 0;
    src_valid = '0;
    src_is_fp = '0;
    src_addr  = '0;
    src_data  = '0;
    rf_busy   = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    do_reset();

    // Single result.
    single_x5();

    // Three sources valid continuously: grants rotate 0,1,2,...
    do_reset();
    for (int i = 0; i < 3; i++) set_src(i, 1, 0, 5'(i + 1), 32'(100 + i));
    for (int n = 0; n < 6; n++) begin
      step(g);
      check("rr_order", g, n % 3);
    end
    src_valid = '0;
    repeat (3) step(g);

    // rf_busy holds the port: FIFO fills to 4, then push and pop share an edge.
    do_reset();
    rf_busy = 1'b1;
    acc = 0;
    set_src(0, 1, 0, 5'd10, 32'h1000);
    for (int n = 0; n < 6; n++) begin
      step(g);
      if (g == 0) begin
        acc++;
        set_src(0, 1, 0, 5'(10 + acc), 32'h1000 + 32'(acc));
      end
    end
    check("busy_accepts", acc, 4);
    check("busy_not_idle", wb_idle, 1'b0);
    rf_busy = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step(g);
      check("full_push_pop", g, 0);
      acc++;
      set_src(0, 1, 0, 5'(10 + acc), 32'h1000 + 32'(acc));
    end
    src_valid = '0;
    repeat (5) step(g);

    // Integer x0 is handshaken but never written; rr_ptr still advances.
    do_reset();
    set_src(1, 1, 0, 5'd0, 32'h1234);
    step(g);
    check("x0_grant", g, 1);
    src_valid = '0;
    #1;
    check("x0_no_we", rf_write_enable, 1'b0);
    check("x0_idle", wb_idle, 1'b1);
    set_src(0, 1, 0, 5'd9, 32'h9);
    set_src(2, 1, 0, 5'd8, 32'h8);
    step(g);
    check("x0_rr_adv", g, 2);
    src_valid = '0;
    repeat (3) step(g);

    // FP register 0 is a normal target.
    do_reset();
    set_src(0, 1, 1, 5'd0, 32'h3F800000);
    step(g);
    src_valid = '0;
    #1;
    check("f0_we", rf_write_enable, 1'b1);
    check("f0_is_fp", rf_is_fp, 1'b1);
    check("f0_data", rf_write_data, 32'h3F800000);
    check("f0_pend", pending_fp, 32'h1);
    step(g);

    // Two writes to x7 behind rf_busy drain in order.
    do_reset();
    rf_busy = 1'b1;
    set_src(0, 1, 0, 5'd7, 32'h11);
    step(g);
    set_src(0, 1, 0, 5'd7, 32'h22);
    step(g);
    src_valid = '0;
    step(g);
    check("x7_pend_q", pending_int, 32'h80);
    rf_busy = 1'b0;
    #1;
    check("x7_first", rf_write_data, 32'h11);
    step(g);
    check("x7_second", rf_write_data, 32'h22);
    check("x7_pend_hold", pending_int[7], 1'b1);
    step(g);
    check("x7_pend_clr", pending_int[7], 1'b0);
    step(g);

    // Reset with three entries queued discards them.
    rf_busy = 1'b1;
    for (int n = 0; n < 3; n++) begin
      set_src(0, 1, n[0], 5'(20 + n), 32'(n));
      step(g);
    end
    src_valid = '0;
    check("q3_not_idle", wb_idle, 1'b0);
    rf_busy = 1'b0;
    do_reset();
    step(g);
    single_x5();

    // Randomized traffic; unaccepted requests are held stable.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!src_valid[i] && $urandom_range(0, 1) == 1)
          set_src(i, 1, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)), $urandom);
      end
      rf_busy = ($urandom_range(0, 3) == 0);
      step(g);
      if (g >= 0) src_valid[g] = 1'b0;
      if (n == 200) begin
        rf_busy = 1'b0;
        do_reset();
      end
    end
    src_valid = '0;
    rf_busy   = 1'b0;
    repeat (6) step(g);
    check("final_idle", wb_idle, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
